nibble_serial_add_ctrl: RTL
===========================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, meaning number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands a, b, cin presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry into nibble 0.
REQ-010 cla_a  output  4  current A slice to the external 4-bit carry-lookahead adder.
REQ-011 cla_b  output  4  current B slice to the external 4-bit carry-lookahead adder.
REQ-012 cla_cin  output  1  carry into the external adder.
REQ-013 cla_sum  input  4  combinational sum returned by the external adder.
REQ-014 cla_cout  input  1  combinational carry returned by the external adder.
REQ-015 out_valid  output  1  result available.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 sum  output  W  registered W-bit result.
REQ-018 cout  output  1  registered final carry.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE and SHALL NOT depend combinationally on any input.
REQ-021 In IDLE, when in_valid=1 on a rising edge: capture a, b and cin into operand/carry registers, clear the slice index to 0, and go to RUN.
REQ-022 In RUN: cla_a = a_reg[4*idx+3:4*idx], cla_b = b_reg[4*idx+3:4*idx], cla_cin = carry_reg, all driven from registers only.
REQ-023 In each RUN cycle: write cla_sum into sum_reg[4*idx+3:4*idx], load carry_reg from cla_cout, and increment idx.
REQ-024 When the RUN cycle with idx = NIBBLES-1 completes: load cout from cla_cout and go to DONE.
REQ-025 Latency: if operands are accepted at edge E, out_valid SHALL rise after edge E+NIBBLES (4 RUN cycles at the default).
REQ-026 In DONE, out_valid SHALL be 1 and sum/cout SHALL be held stable; when out_ready=1 on an edge, go to IDLE.
REQ-027 There is no same-cycle DONE-to-accept path: new operands SHALL be accepted no earlier than the cycle after out_valid falls.
REQ-028 in_valid asserted in RUN or DONE SHALL be ignored, with no effect on any register.
REQ-029 Outside RUN, cla_a, cla_b and cla_cin SHALL be 0.
REQ-030 sum and cout SHALL retain the last result in IDLE and are overwritten only during RUN.
REQ-031 Only cla_sum bits are stored; no addition SHALL be performed internally.
REQ-032 idx is ceil(log2(NIBBLES)) bits wide; it SHALL never exceed NIBBLES-1 and is cleared on accept.

Reset
REQ-033 While rst_n=0, regardless of clk: state = IDLE; idx, a_reg, b_reg, carry_reg, sum and cout = 0; out_valid = 0; in_ready = 1 immediately.
REQ-034 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid pulse follows the release of reset.
REQ-035 Release of rst_n SHALL be sampled synchronously: the first accept is possible at the first rising edge with rst_n=1.

Verification (NIBBLES=4, bench models the external adder as a combinational 4-bit adder)
REQ-036 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid after 4 RUN cycles.
REQ-037 a=0xFFFF, b=0x0000, cin=1 -> carry ripples through all slices; cla_cin=1 in every RUN cycle; sum=0x0000, cout=1.
REQ-038 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; slice 0 sees cla_cin=0.
REQ-039 out_ready held 0 for 3 cycles in DONE -> out_valid=1, sum stable, in_ready=0 throughout; IDLE on the first edge with out_ready=1.
REQ-040 in_valid=1 with a=0xAAAA during RUN of 0x1111+0x2222 -> result 0x3333, second request ignored.
REQ-041 rst_n pulsed low during RUN cycle 2 -> all outputs 0 and in_ready=1 immediately; no out_valid after release; next operation 0x0F0F+0x00F1 gives 0x1000, cout=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller.
// Walks two W-bit operands (W = 4*NIBBLES) through an external 4-bit
// carry-lookahead adder one nibble per cycle, collecting the returned sum
// slices and ripple carry into a registered result.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin)
//   cla_a, cla_b, cla_cin  slice presented to the external adder
//   cla_sum, cla_cout    combinational result from the external adder
//   out_valid / out_ready  result handshake (sum, cout)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1, result of last op retained
// RUN   | one nibble per cycle through the external adder
// DONE  | out_valid=1, result held until out_ready
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic [3:0]           cla_a,
  output logic [3:0]           cla_b,
  output logic                 cla_cin,
  input  logic [3:0]           cla_sum,
  input  logic                 cla_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  // A single-nibble build still needs a 1-bit index to be legal.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry_reg;
  logic [W-1:0]    sum_reg;
  logic            cout_reg;

  logic            accept;
  logic            run_last;
  logic [IW+1:0]   slice_base;

  assign accept     = (state == IDLE) && in_valid;
  assign run_last   = (state == RUN) && (idx == LAST_IDX);
  assign slice_base = {idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)  state_nxt = RUN;
      RUN:  if (run_last)  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= a;
      b_reg     <= b;
      carry_reg <= cin;
    end else if (state == RUN) begin
      sum_reg[slice_base +: 4] <= cla_sum;
      carry_reg                <= cla_cout;
      if (run_last) begin
        // Park the index at 0 so it never passes NIBBLES-1.
        idx      <= '0;
        cout_reg <= cla_cout;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Adder-facing slice comes straight from registers; zero outside RUN.
  always_comb begin
    cla_a   = 4'h0;
    cla_b   = 4'h0;
    cla_cin = 1'b0;
    if (state == RUN) begin
      cla_a   = a_reg[slice_base +: 4];
      cla_b   = b_reg[slice_base +: 4];
      cla_cin = carry_reg;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule
